// File: rtl/hex_scroll_pkg.sv
// Shared definitions for the HEX3..HEX0 scroll controller:
// character codes, controller states and the index wrap helper.
package hex_scroll_pkg;

    // Non-hex character codes (0x00..0x0F are the hex glyphs)
    localparam logic [4:0] CH_BLANK = 5'h10;
    localparam logic [4:0] CH_DASH  = 5'h11;
    localparam logic [4:0] CH_L     = 5'h12;
    localparam logic [4:0] CH_P     = 5'h13;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Reduce v (= pos + k, at most 10) modulo len (1..8). For short
    // messages v can exceed 2*len, so subtract repeatedly; four rounds
    // cover the worst case len=1, pos=0, k=3. len=0 returns v unchanged.
    function automatic logic [2:0] wrap_idx(input logic [3:0] v, input logic [3:0] len);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (len != 4'd0 && r >= len) begin
                r = r - len;
            end
        end
        return r[2:0];
    endfunction

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// Character load stream: valid/ready handshake with a last marker.
interface hex_scroll_ctrl_if;
    logic       load_valid;
    logic       load_ready;
    logic [4:0] load_char;
    logic       load_last;

    // Producer side (host FSM or switch logic)
    modport master (
        output load_valid,
        output load_char,
        output load_last,
        input  load_ready
    );

    // Consumer side (the scroll controller)
    modport slave (
        input  load_valid,
        input  load_char,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/hex_scroll_ctrl_seg7_char_dec.sv
// Combinational character code to active-low seven-segment pattern (g..a).
module seg7_char_dec
    import hex_scroll_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    // Glyph table; unlisted codes render blank
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'h00:   seg = 7'b1000000;
            5'h01:   seg = 7'b1111001;
            5'h02:   seg = 7'b0100100;
            5'h03:   seg = 7'b0110000;
            5'h04:   seg = 7'b0011001;
            5'h05:   seg = 7'b0010010;
            5'h06:   seg = 7'b0000010;
            5'h07:   seg = 7'b1111000;
            5'h08:   seg = 7'b0000000;
            5'h09:   seg = 7'b0010000;
            5'h0A:   seg = 7'b0001000;
            5'h0B:   seg = 7'b0000011;
            5'h0C:   seg = 7'b1000110;
            5'h0D:   seg = 7'b0100001;
            5'h0E:   seg = 7'b0000110;
            5'h0F:   seg = 7'b0001110;
            CH_DASH: seg = 7'b0111111;
            CH_L:    seg = 7'b1000111;
            CH_P:    seg = 7'b0001100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Loadable message scroller for the HEX3..HEX0 displays. A message of up
// to MSG_LEN characters is loaded over a valid/ready stream and rotated
// across the four digits, either automatically every STEP_DIV cycles or
// one step at a time while held.
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int STEP_DIV = 50_000_000,
    parameter int MSG_LEN  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    hex_scroll_ctrl_if.slave lif,
    input  logic             run,
    input  logic             dir,
    input  logic             step,
    output logic [6:0]       hex3,
    output logic [6:0]       hex2,
    output logic [6:0]       hex1,
    output logic [6:0]       hex0,
    output logic [2:0]       pos,
    output logic             running
);

    localparam int            PW       = $clog2(STEP_DIV);
    localparam logic [PW-1:0] TERM     = PW'(STEP_DIV - 1);
    localparam logic [2:0]    LAST_IDX = 3'(MSG_LEN - 1);

    state_t        state_reg, state_next;
    logic [2:0]    pos_reg, pos_next;
    logic [3:0]    len_reg, len_next;
    logic [2:0]    idx_reg, idx_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          running_reg;
    logic [4:0]    buf_reg [MSG_LEN];

    logic          xfer;
    logic          buf_we;
    logic [2:0]    wr_idx;
    logic [2:0]    pos_adv;
    logic [3:0]    len_m1;

    assign lif.load_ready = (state_reg == ST_EMPTY) || (state_reg == ST_LOAD);
    assign xfer           = lif.load_valid && lif.load_ready;
    // The first character of a message always lands in slot 0
    assign wr_idx         = (state_reg == ST_EMPTY) ? 3'd0 : idx_reg;
    assign len_m1         = len_reg - 4'd1;

    // Head position one step along the selected direction, wrapping at len
    always_comb begin
        pos_adv = pos_reg;
        if (dir) begin
            pos_adv = (pos_reg == 3'd0) ? len_m1[2:0] : pos_reg - 3'd1;
        end else begin
            pos_adv = ({1'b0, pos_reg} == len_m1) ? 3'd0 : pos_reg + 3'd1;
        end
    end

    // Next-state logic: clear beats loading, loading beats step/tick
    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        presc_next = presc_reg;
        buf_we     = 1'b0;

        if (clear) begin
            state_next = ST_EMPTY;
            pos_next   = 3'd0;
            len_next   = 4'd0;
            idx_next   = 3'd0;
            presc_next = '0;
        end else begin
            case (state_reg)
                ST_EMPTY, ST_LOAD: begin
                    if (xfer) begin
                        buf_we     = 1'b1;
                        idx_next   = wr_idx + 3'd1;
                        state_next = ST_LOAD;
                        if (lif.load_last || wr_idx == LAST_IDX) begin
                            len_next   = {1'b0, wr_idx} + 4'd1;
                            pos_next   = 3'd0;
                            presc_next = '0;
                            state_next = run ? ST_RUN : ST_HOLD;
                        end
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        // Leaving RUN takes no step, even on a terminal count
                        state_next = ST_HOLD;
                        presc_next = '0;
                    end else if (presc_reg == TERM) begin
                        presc_next = '0;
                        pos_next   = pos_adv;
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end
                ST_HOLD: begin
                    presc_next = '0;
                    if (step) begin
                        pos_next = pos_adv;
                    end
                    if (run) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Controller state register; running tracks the registered state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_EMPTY;
            pos_reg     <= 3'd0;
            len_reg     <= 4'd0;
            idx_reg     <= 3'd0;
            presc_reg   <= '0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pos_reg     <= pos_next;
            len_reg     <= len_next;
            idx_reg     <= idx_next;
            presc_reg   <= presc_next;
            running_reg <= (state_next == ST_RUN);
        end
    end

    // Message buffer, written one character per accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                buf_reg[i] <= CH_BLANK;
            end
        end else begin
            for (int i = 0; i < MSG_LEN; i++) begin
                if (buf_we && wr_idx == 3'(i)) begin
                    buf_reg[i] <= lif.load_char;
                end
            end
        end
    end

    // One digit per lane: lane gi shows buf[(pos+gi) mod len]; with no
    // finished message (len=0) every lane is blank
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dig
            logic [2:0] sel;
            logic [4:0] ch;
            logic [6:0] seg_c;
            logic [6:0] seg_reg;

            assign sel = wrap_idx({1'b0, pos_reg} + 4'(gi), len_reg);
            assign ch  = (len_reg == 4'd0) ? CH_BLANK : buf_reg[sel];

            seg7_char_dec u_dec (
                .code (ch),
                .seg  (seg_c)
            );

            // Registered segment output for this lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    seg_reg <= SEG_BLANK;
                end else begin
                    seg_reg <= seg_c;
                end
            end
        end
    endgenerate

    assign hex3    = g_dig[0].seg_reg;
    assign hex2    = g_dig[1].seg_reg;
    assign hex1    = g_dig[2].seg_reg;
    assign hex0    = g_dig[3].seg_reg;
    assign pos     = pos_reg;
    assign running = running_reg;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl: directed scenarios followed by randomized
// load/run/dir/step traffic, all checked every cycle against a message
// level reference model.
module tb_hex_scroll_ctrl;

    localparam int SD = 4;
    localparam int ML = 8;

    logic       clk = 1'b0;
    logic       rst, clear, run, dir, step;
    logic [6:0] hex3, hex2, hex1, hex0;
    logic [2:0] pos;
    logic       running;

    hex_scroll_ctrl_if lif ();

    hex_scroll_ctrl #(.STEP_DIV(SD), .MSG_LEN(ML)) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .lif     (lif),
        .run     (run),
        .dir     (dir),
        .step    (step),
        .hex3    (hex3),
        .hex2    (hex2),
        .hex1    (hex1),
        .hex0    (hex0),
        .pos     (pos),
        .running (running)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model: mode, loaded message, head position, cycles in RUN
    typedef enum {M_EMPTY, M_LOAD, M_RUN, M_HOLD} mmode_t;
    mmode_t m_mode;
    int     msg[$];
    int     m_pos;
    int     m_rc;
    int     tx[$];

    function automatic logic [6:0] glyph(input int c);
        case (c)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  15: return 7'b0001110;
            17: return 7'b0111111;  18: return 7'b1000111;
            19: return 7'b0001100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic advance();
        int n;
        n = msg.size();
        m_pos = dir ? (m_pos + n - 1) % n : (m_pos + 1) % n;
    endtask

    task automatic model_update();
        if (rst || clear) begin
            m_mode = M_EMPTY;
            msg.delete();
            m_pos = 0;
            m_rc  = 0;
        end else begin
            case (m_mode)
                M_EMPTY, M_LOAD: begin
                    if (lif.load_valid) begin
                        msg.push_back(int'(lif.load_char));
                        if (lif.load_last || msg.size() == ML) begin
                            m_pos  = 0;
                            m_rc   = 0;
                            m_mode = run ? M_RUN : M_HOLD;
                        end else begin
                            m_mode = M_LOAD;
                        end
                    end
                end
                M_RUN: begin
                    if (!run) begin
                        m_mode = M_HOLD;
                        m_rc   = 0;
                    end else begin
                        m_rc++;
                        if (m_rc % SD == 0) advance();
                    end
                end
                default: begin
                    if (step) advance();
                    if (run) begin
                        m_mode = M_RUN;
                        m_rc   = 0;
                    end
                end
            endcase
        end
    endtask

    // One clock: displays reflect the state before the edge, everything
    // else reflects the state after it
    task automatic cycle();
        logic [6:0] e [4];
        for (int k = 0; k < 4; k++) begin
            if (!rst && (m_mode == M_RUN || m_mode == M_HOLD))
                e[k] = glyph(msg[(m_pos + k) % msg.size()]);
            else
                e[k] = 7'h7F;
        end
        model_update();
        @(posedge clk);
        #1;
        chk("hex3", 32'(hex3), 32'(e[0]));
        chk("hex2", 32'(hex2), 32'(e[1]));
        chk("hex1", 32'(hex1), 32'(e[2]));
        chk("hex0", 32'(hex0), 32'(e[3]));
        chk("pos", 32'(pos), 32'(m_pos));
        chk("running", 32'(running), 32'(m_mode == M_RUN));
        chk("load_ready", 32'(lif.load_ready), 32'(m_mode == M_EMPTY || m_mode == M_LOAD));
    endtask

    // Offer every character in tx back to back, optionally with idle gaps
    task automatic send(input bit use_last, input bit gaps);
        for (int i = 0; i < tx.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                lif.load_valid = 1'b0;
                cycle();
            end
            lif.load_valid = 1'b1;
            lif.load_char  = 5'(tx[i]);
            lif.load_last  = use_last && (i == tx.size() - 1);
            cycle();
        end
        lif.load_valid = 1'b0;
        lif.load_last  = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        int saved;
        bit hit;
        rst = 1'b1; clear = 1'b0; run = 1'b0; dir = 1'b0; step = 1'b0;
        lif.load_valid = 1'b0; lif.load_char = 5'd0; lif.load_last = 1'b0;
        m_mode = M_EMPTY; m_pos = 0; m_rc = 0;
        cycle();
        rst = 1'b0;
        chk("rst_hex3", 32'(hex3), 32'h7F);
        chk("rst_ready", 32'(lif.load_ready), 32'd1);
        cycle();

        // d,E,1,0 scrolling right every SD cycles
        run = 1'b1; dir = 1'b1;
        tx = '{13, 14, 1, 0};
        send(1'b1, 1'b0);
        cycle();
        chk("dE10_hex3", 32'(hex3), 32'b0100001);
        chk("dE10_hex2", 32'(hex2), 32'b0000110);
        chk("dE10_hex1", 32'(hex1), 32'b1111001);
        chk("dE10_hex0", 32'(hex0), 32'b1000000);
        for (int i = 0; i < 4; i++) cycle();
        chk("0dE1_hex3", 32'(hex3), 32'b1000000);
        for (int i = 0; i < 12; i++) cycle();

        // Two characters in HOLD, stepped left
        pulse_clear();
        run = 1'b0; dir = 1'b0;
        tx = '{10, 5};
        send(1'b1, 1'b0);
        cycle();
        chk("A5_hex3", 32'(hex3), 32'b0001000);
        chk("A5_hex2", 32'(hex2), 32'b0010010);
        for (int i = 0; i < 4; i++) begin
            step = 1'b1; cycle();
            step = 1'b0; cycle();
        end

        // Eight characters without last, then a ninth offer
        pulse_clear();
        run = 1'b1;
        tx = '{1, 2, 3, 4, 5, 6, 7, 8};
        send(1'b0, 1'b0);
        lif.load_valid = 1'b1; lif.load_char = 5'h0F;
        cycle();
        chk("ninth_ready", 32'(lif.load_ready), 32'd0);
        lif.load_valid = 1'b0;

        // step is ignored while running
        step = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        step = 1'b0;

        // Drop run on the terminal-count cycle
        for (int i = 0; i < 2 * SD && ((m_rc + 1) % SD) != 0; i++) cycle();
        saved = m_pos;
        run = 1'b0;
        cycle();
        chk("droprun_pos", 32'(pos), 32'(saved));
        chk("droprun_running", 32'(running), 32'd0);

        // Reset while running at pos 2
        run = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cycle();
            hit = (m_mode == M_RUN && m_pos == 2);
        end
        chk("reach_pos2", 32'(hit), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rstrun_pos", 32'(pos), 32'd0);
        chk("rstrun_hex0", 32'(hex0), 32'h7F);

        // Clear in the middle of a load, then reload from slot 0
        run = 1'b0;
        tx = '{3, 3, 3};
        send(1'b0, 1'b0);
        pulse_clear();
        chk("midclear_hex3", 32'(hex3), 32'h7F);
        tx = '{18, 19, 17};
        send(1'b1, 1'b0);
        cycle();
        chk("reload_hex3", 32'(hex3), 32'b1000111);

        // Randomized traffic
        for (int r = 0; r < 25; r++) begin
            int n;
            pulse_clear();
            n = $urandom_range(1, ML);
            tx.delete();
            for (int i = 0; i < n; i++) tx.push_back(int'($urandom_range(0, 31)));
            run = 1'($urandom_range(0, 1));
            dir = 1'($urandom_range(0, 1));
            send((n < ML) || ($urandom_range(0, 1) == 1), 1'b1);
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 7) == 0) run = ~run;
                if ($urandom_range(0, 5) == 0) dir = ~dir;
                step = ($urandom_range(0, 3) == 0);
                cycle();
                step = 1'b0;
            end
            if (r % 7 == 3) begin
                rst = 1'b1; cycle(); rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired, observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
